// File: rtl/sled_btn_ctrl_if.sv
// Button/mode bundle between the board buttons and the slider mode logic.
// The master drives the raw buttons; the slave (sled_btn_ctrl) returns the mode word.
interface sled_btn_ctrl_if;
  localparam int unsigned MODE_W = 2;

  logic              btn_speed;
  logic              btn_hold;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;

  modport master (
    output btn_speed,
    output btn_hold,
    input  mode,
    input  mode_chg
  );

  modport slave (
    input  btn_speed,
    input  btn_hold,
    output mode,
    output mode_chg
  );
endinterface

// File: rtl/sled_btn_ctrl.sv
// Debounced two-button front end producing the slider's 2-bit speed/hold mode word
// (00 hold, 01 slow, 10 medium, 11 fast) plus a one-cycle change strobe.
module sled_btn_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic            clk,
  input logic            rst,
  sled_btn_ctrl_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned N_BTN     = 2;
  localparam int unsigned BTN_SPEED = 0;
  localparam int unsigned BTN_HOLD  = 1;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 2'b00;
  localparam logic [MODE_W-1:0] SPEED_MIN  = 2'b01;
  localparam logic [MODE_W-1:0] SPEED_MAX  = 2'b11;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] press;

  assign raw = {bus.btn_hold, bus.btn_speed};

  // Identical, independent synchronizer -> debouncer -> rising-edge path per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   db;
    logic                   db_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[i]};
      end
    end

    // Accept a new level only after it has differed from db for DEBOUNCE_CNT cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        db   <= 1'b0;
        db_d <= 1'b0;
      end else begin
        db_d <= db;
        if (sync[SYNC_STAGES-1] == db) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
          db  <= sync[SYNC_STAGES-1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[i] = db & ~db_d;
  end

  logic [MODE_W-1:0] speed;
  logic              held;
  logic [MODE_W-1:0] mode_word;
  logic              chg;

  logic [MODE_W-1:0] speed_nxt;
  logic              held_nxt;
  logic [MODE_W-1:0] mode_nxt;

  // Next control values; mode is derived from the post-update speed/held.
  always_comb begin
    speed_nxt = speed;
    held_nxt  = held;
    if (press[BTN_SPEED]) begin
      speed_nxt = (speed == SPEED_MAX) ? SPEED_MIN : speed + MODE_W'(1);
    end
    if (press[BTN_HOLD]) begin
      held_nxt = ~held;
    end
    mode_nxt = held_nxt ? MODE_HOLD : speed_nxt;
  end

  // Display starts frozen at the slowest speed until hold is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed     <= SPEED_MIN;
      held      <= 1'b1;
      mode_word <= MODE_HOLD;
      chg       <= 1'b0;
    end else begin
      speed     <= speed_nxt;
      held      <= held_nxt;
      mode_word <= mode_nxt;
      chg       <= (mode_nxt != mode_word);
    end
  end

  assign bus.mode     = mode_word;
  assign bus.mode_chg = chg;

endmodule

// File: doc/sled_btn_ctrl.md
# sled_btn_ctrl

Push-button front end for the sliding-LED display. Debounces two board buttons and turns their presses into the 2-bit speed/hold mode word the slider consumes: 00 = hold, 01 = slow, 10 = medium, 11 = fast. It replaces the raw slide switches as the mode source and adds a one-cycle change strobe for status logic.

## Interface
- DEBOUNCE_CNT, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 1.
- SYNC_STAGES, 2, synchronizer flip-flops per button; must be ≥ 2.

- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- btn_speed  input  1  raw asynchronous button; each accepted press advances the speed.
- btn_hold  input  1  raw asynchronous button; each accepted press toggles hold.
- mode  output  2  registered mode word to the slider.
- mode_chg  output  1  single-cycle strobe, high in the first cycle `mode` shows a new value.

## Operation
- Per-button path: SYNC_STAGES-deep synchronizer, then debouncer, then rising-edge detector. The two paths are identical and independent.
- Debouncer state:
  - `db` holds the accepted level; it resets to 0.
  - `cnt` has width $clog2(DEBOUNCE_CNT+1).
  - When the synchronizer output equals `db`: clear `cnt`.
  - When it differs: increment `cnt`. On the cycle the difference has persisted DEBOUNCE_CNT consecutive cycles, set `db` to the synchronizer output and clear `cnt`.
  - Any return to the `db` level before then clears `cnt`. Short glitches are therefore discarded.
- Edge: `press` = `db` & ~`db_d`, where `db_d` is `db` delayed one cycle. Releases (falling edges) generate nothing.
- Control registers:
  - `speed`: 2 bits, legal values 01, 10, 11, reset value 01.
  - `held`: 1 bit, reset value 1, so the display is frozen after reset until the user releases hold.
- A speed press advances `speed` in the order 01 → 10 → 11 → 01 (wraps from 11 back to 01; never 00).
- A hold press toggles `held`.
- Simultaneous presses in the same cycle apply both: `speed` advances and `held` toggles.
- A speed press while held updates `speed` but `mode` stays 00. The new speed appears when hold is released.
- `mode` is registered: next `mode` = `held` ? 00 : `speed`, computed from the post-update control values.
- `mode_chg` is registered and asserted for one cycle exactly when the next `mode` differs from the current `mode`.
  - A speed press while held gives no strobe.
  - A simultaneous press that leaves `mode` unchanged gives no strobe.
- A button held through reset deassertion is treated as a new press: it produces a press once debounced.

## Timing
- Reset values: `mode` = 00, `mode_chg` = 0, `speed` = 01, `held` = 1, all synchronizer flops = 0, `db` = 0, `db_d` = 0, `cnt` = 0.
- Latency: let edge 1 be the first clk edge that samples a clean asserted button. `mode` and `mode_chg` take their new values on edge SYNC_STAGES + DEBOUNCE_CNT + 1. For the defaults this is edge 1000003.
- Release latency is the same, but has no visible effect.
- Minimum accepted pulse: DEBOUNCE_CNT stable cycles at the synchronizer output.
- `mode_chg` is high for exactly one cycle per change. Two changes can be no closer than DEBOUNCE_CNT cycles apart per button.
- Reset mid-debounce: all state returns to reset values immediately. A pending press is lost, and `mode_chg` drops asynchronously.
- No combinational path from any input to any output.

## Test plan
- All tests use DEBOUNCE_CNT = 4 and SYNC_STAGES = 2.
- Reset release with buttons low → `mode` = 00 and `mode_chg` = 0 for 50 cycles.
- btn_hold high for 10 cycles at edge 1 → `mode` = 01 with `mode_chg` = 1 on edge 7 only. Release → no further change.
- Hold released, then three btn_speed presses of 10 cycles each, separated by 10 low cycles → `mode` sequence 10, 11, 01, with one `mode_chg` strobe each.
- btn_speed pulses of 3 cycles, plus a 1-0-1-0 glitch train → `mode` unchanged and no `mode_chg`.
- Hold released at `mode` = 01, then btn_speed and btn_hold rise on the same edge → on edge 7, `mode` = 00 (hold re-engaged) with `mode_chg` = 1. A later hold press → `mode` = 10.
- Hold engaged, then btn_speed pressed → no `mode_chg` and `mode` stays 00. Then rst pulsed during a btn_hold debounce (cnt = 2) → `mode` = 00 immediately. btn_hold still high after reset → `mode` = 01 on edge 7 after reset release.
